// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first, repeated
// repeat_n times with gap idle cycles between repetitions, then pulses done.
module sequence_generator #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [GAP_W-1:0] gap,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] sent_count
);

   localparam int BIT_W = $clog2(PAT_W);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      GAP  = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t             state_q,      state_d;
   logic [PAT_W-1:0]   shift_q,      shift_d;
   logic [BIT_W-1:0]   bit_cnt_q,    bit_cnt_d;
   logic [CNT_W-1:0]   rep_q,        rep_d;
   logic [GAP_W-1:0]   gap_cnt_q,    gap_cnt_d;
   logic [PAT_W-1:0]   pat_q,        pat_d;
   logic [GAP_W-1:0]   gap_q,        gap_d;
   logic [CNT_W-1:0]   sent_count_q, sent_count_d;
   logic               dout_q,       dout_d;
   logic               dout_valid_q, dout_valid_d;
   logic               busy_q,       busy_d;
   logic               done_q,       done_d;
   logic               last_bit_s;

   assign last_bit_s = (bit_cnt_q == BIT_W'(PAT_W - 1));

   // Next-state logic; output flops are loaded with the values of the state being entered,
   // so each registered output lines up with the registered state.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      rep_d        = rep_q;
      gap_cnt_d    = gap_cnt_q;
      pat_d        = pat_q;
      gap_d        = gap_q;
      sent_count_d = sent_count_q;
      dout_d       = 1'b0;
      dout_valid_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               pat_d        = pattern;
               gap_d        = gap;
               rep_d        = repeat_n;
               sent_count_d = {CNT_W{1'b0}};
               bit_cnt_d    = {BIT_W{1'b0}};
               gap_cnt_d    = {GAP_W{1'b0}};
               if (repeat_n != {CNT_W{1'b0}}) begin
                  state_d      = SEND;
                  shift_d      = pattern;
                  dout_d       = pattern[PAT_W-1];
                  dout_valid_d = 1'b1;
                  busy_d       = 1'b1;
               end else begin
                  state_d = DONE;
                  shift_d = {PAT_W{1'b0}};
                  done_d  = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end

         SEND: begin
            if (!last_bit_s) begin
               shift_d      = {shift_q[PAT_W-2:0], 1'b0};
               bit_cnt_d    = bit_cnt_q + BIT_W'(1);
               dout_d       = shift_q[PAT_W-2];
               dout_valid_d = 1'b1;
               busy_d       = 1'b1;
            end else begin
               // Pattern complete: rep_q still counts the repetition just finished.
               sent_count_d = sent_count_q + CNT_W'(1);
               rep_d        = rep_q - CNT_W'(1);
               bit_cnt_d    = {BIT_W{1'b0}};
               if (rep_q == CNT_W'(1)) begin
                  state_d = DONE;
                  shift_d = {PAT_W{1'b0}};
                  done_d  = 1'b1;
               end else if (gap_q == {GAP_W{1'b0}}) begin
                  state_d      = SEND;
                  shift_d      = pat_q;
                  dout_d       = pat_q[PAT_W-1];
                  dout_valid_d = 1'b1;
                  busy_d       = 1'b1;
               end else begin
                  state_d   = GAP;
                  shift_d   = {PAT_W{1'b0}};
                  gap_cnt_d = gap_q;
                  busy_d    = 1'b1;
               end
            end
         end

         GAP: begin
            busy_d = 1'b1;
            if (gap_cnt_q == GAP_W'(1)) begin
               state_d      = SEND;
               gap_cnt_d    = {GAP_W{1'b0}};
               shift_d      = pat_q;
               bit_cnt_d    = {BIT_W{1'b0}};
               dout_d       = pat_q[PAT_W-1];
               dout_valid_d = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d   = IDLE;
            shift_d   = {PAT_W{1'b0}};
            bit_cnt_d = {BIT_W{1'b0}};
            rep_d     = {CNT_W{1'b0}};
            gap_cnt_d = {GAP_W{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         shift_q      <= {PAT_W{1'b0}};
         bit_cnt_q    <= {BIT_W{1'b0}};
         rep_q        <= {CNT_W{1'b0}};
         gap_cnt_q    <= {GAP_W{1'b0}};
         pat_q        <= {PAT_W{1'b0}};
         gap_q        <= {GAP_W{1'b0}};
         sent_count_q <= {CNT_W{1'b0}};
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         rep_q        <= rep_d;
         gap_cnt_q    <= gap_cnt_d;
         pat_q        <= pat_d;
         gap_q        <= gap_d;
         sent_count_q <= sent_count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign state      = state_q;
   assign sent_count = sent_count_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: directed scenarios plus randomized
// transactions compared cycle by cycle against an expected-waveform model.
module tb_sequence_generator;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] pattern;
   logic [3:0] repeat_n;
   logic [2:0] gap;
   logic       dout;
   logic       dout_valid;
   logic       busy;
   logic       done;
   logic [1:0] state;
   logic [3:0] sent_count;

   int n_checks = 0;
   int n_errors = 0;
   int last_cnt = 0;

   typedef struct {
      logic [1:0] st;
      logic       v;
      logic       d;
      logic       dn;
      int         cnt;
   } cyc_t;

   cyc_t exp_q[$];

   sequence_generator #(.PAT_W(4), .CNT_W(4), .GAP_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pattern    (pattern),
      .repeat_n   (repeat_n),
      .gap        (gap),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .done       (done),
      .state      (state),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected cycles following an accepted start, listed from the rules of the protocol.
   task automatic build_model(input logic [3:0] p, input int rn, input int g);
      cyc_t c;
      exp_q.delete();
      for (int r = 0; r < rn; r++) begin
         for (int b = 0; b < 4; b++) begin
            c.st = 2'b01; c.v = 1'b1; c.d = p[3-b]; c.dn = 1'b0; c.cnt = r;
            exp_q.push_back(c);
         end
         if (r < rn - 1) begin
            for (int k = 0; k < g; k++) begin
               c.st = 2'b10; c.v = 1'b0; c.d = 1'b0; c.dn = 1'b0; c.cnt = r + 1;
               exp_q.push_back(c);
            end
         end
      end
      c.st = 2'b11; c.v = 1'b0; c.d = 1'b0; c.dn = 1'b1; c.cnt = rn;
      exp_q.push_back(c);
   endtask

   task automatic check_idle(input string tag, input int cnt);
      check_eq({tag, ".state"}, state, 2'b00);
      check_eq({tag, ".valid"}, dout_valid, 1'b0);
      check_eq({tag, ".dout"},  dout, 1'b0);
      check_eq({tag, ".busy"},  busy, 1'b0);
      check_eq({tag, ".done"},  done, 1'b0);
      check_eq({tag, ".cnt"},   sent_count, cnt);
   endtask

   // junk: 0 none, 1 random ignored starts, 2 start with pattern 0000 every busy cycle.
   task automatic run_seq(input logic [3:0] p, input logic [3:0] rn, input logic [2:0] g,
                          input int junk, input int abort_at, input string tag);
      pattern  = p;
      repeat_n = rn;
      gap      = g;
      start    = 1'b1;
      build_model(p, int'(rn), int'(g));
      tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         string t;
         t = $sformatf("%s[%0d]", tag, i);
         check_eq({t, ".state"}, state, exp_q[i].st);
         check_eq({t, ".valid"}, dout_valid, exp_q[i].v);
         check_eq({t, ".done"},  done, exp_q[i].dn);
         check_eq({t, ".busy"},  busy, (exp_q[i].st == 2'b01 || exp_q[i].st == 2'b10));
         check_eq({t, ".cnt"},   sent_count, exp_q[i].cnt);
         if (exp_q[i].st != 2'b11)
            check_eq({t, ".dout"}, dout, exp_q[i].d);
         if (i == abort_at) begin
            rst   = 1'b0;
            start = 1'b0;
            tick();
            check_idle({tag, ".rst"}, 0);
            rst = 1'b1;
            tick();
            check_idle({tag, ".post_rst"}, 0);
            last_cnt = 0;
            return;
         end
         if (junk == 2) begin
            start   = 1'b1;
            pattern = 4'b0000;
         end else begin
            start    = (junk == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            pattern  = 4'($urandom);
            repeat_n = 4'($urandom);
            gap      = 3'($urandom);
         end
         tick();
      end
      start = 1'b0;
      check_idle({tag, ".end"}, int'(rn));
      last_cnt = int'(rn);
   endtask

   task automatic idle_cycles(input int n);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         check_idle("idle", last_cnt);
      end
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      pattern  = 4'b0000;
      repeat_n = 4'd0;
      gap      = 3'd0;
      tick();
      tick();
      check_idle("reset", 0);
      rst = 1'b1;
      tick();
      check_idle("reset_rel", 0);

      run_seq(4'b1011, 4'd1, 3'd0, 0, -1, "t1");
      run_seq(4'b1011, 4'd2, 3'd2, 0, -1, "t2");
      run_seq(4'b0110, 4'd3, 3'd0, 0, -1, "t3");
      run_seq(4'b1111, 4'd0, 3'd5, 0, -1, "t4");
      run_seq(4'b1011, 4'd1, 3'd0, 2, -1, "t5");
      run_seq(4'b1011, 4'd1, 3'd0, 0, -1, "t5_next");
      run_seq(4'b1011, 4'd2, 3'd2, 0, 1,  "t6");
      run_seq(4'b1011, 4'd1, 3'd0, 0, -1, "t6_fresh");
      idle_cycles(2);

      for (int n = 0; n < 40; n++) begin
         int ab;
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
         run_seq(4'($urandom), 4'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
                 1, ab, $sformatf("rnd%0d", n));
         idle_cycles(int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
